// File: rtl/sdft_pkg.sv
// sdft_pkg
// Shared helpers for the sliding-DFT bin engine.
//   sat_result_t : value plus a flag telling whether it was clamped
//   sign_extend  : sign-extend the low 'width' bits of a raw vector to 64 bits
//   cplx_re/im   : unpack one signed component of a {re, im} complex bus
//   cplx_pack    : pack two components back into a {re, im} bus
//   saturate     : clamp a 64-bit signed value to a 'width'-bit signed range
//   round_shift  : round half-up while dropping 'frac' fractional bits
// All helpers work on 64/128-bit containers so any WORD_WIDTH up to 31 fits.
package sdft_pkg;

    typedef struct packed {
        logic signed [63:0] value;
        logic               sat;
    } sat_result_t;

    function automatic logic signed [63:0] sign_extend(input logic [63:0] raw, input int width);
        logic signed [63:0] shifted;
        shifted = $signed(raw << (64 - width));
        return shifted >>> (64 - width);
    endfunction

    function automatic logic signed [63:0] cplx_re(input logic [127:0] bus, input int width);
        logic [127:0] upper;
        upper = bus >> width;
        return sign_extend(upper[63:0], width);
    endfunction

    function automatic logic signed [63:0] cplx_im(input logic [127:0] bus, input int width);
        return sign_extend(bus[63:0], width);
    endfunction

    function automatic logic [127:0] cplx_pack(input logic signed [63:0] re,
                                               input logic signed [63:0] im,
                                               input int width);
        logic [127:0] mask;
        mask = (128'd1 << width) - 128'd1;
        return ((128'(re) & mask) << width) | (128'(im) & mask);
    endfunction

    function automatic sat_result_t saturate(input logic signed [63:0] value, input int width);
        sat_result_t        res;
        logic signed [63:0] max_val;
        logic signed [63:0] min_val;
        max_val   = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_val   = -(64'sd1 <<< (width - 1));
        res.value = value;
        res.sat   = 1'b0;
        if (value > max_val) begin
            res.value = max_val;
            res.sat   = 1'b1;
        end else if (value < min_val) begin
            res.value = min_val;
            res.sat   = 1'b1;
        end
        return res;
    endfunction

    // Adding half an LSB before the arithmetic shift gives round-half-up
    // (towards +inf on exact ties) for both signs.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] value, input int frac);
        if (frac <= 0) begin
            return value;
        end
        return (value + (64'sd1 <<< (frac - 1))) >>> frac;
    endfunction

endpackage

// File: rtl/sdft_cmult.sv
// sdft_cmult
// Pipelined full-precision complex multiplier P = A * B with a side-band tag.
// Ports:
//   clk, reset_n        : clock, async active-low reset (valid bits only)
//   valid, tag          : slot valid and opaque tag travelling with the data
//   a_re, a_im          : first operand (signed WORD_WIDTH)
//   b_re, b_im          : second operand (signed WORD_WIDTH)
//   prod_valid/prod_tag : delayed valid and tag, aligned with the product
//   prod_re, prod_im    : full-precision product (2*WORD_WIDTH+1 bits)
//   busy                : any valid slot held inside the multiplier
// Latency is exactly MULT_LATENCY register stages.
module sdft_cmult #(
    parameter  int WORD_WIDTH   = 16,
    parameter  int MULT_LATENCY = 3,
    parameter  int TAG_W        = 1,
    localparam int PW           = 2 * WORD_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         valid,
    input  logic        [TAG_W-1:0]      tag,
    input  logic signed [WORD_WIDTH-1:0] a_re,
    input  logic signed [WORD_WIDTH-1:0] a_im,
    input  logic signed [WORD_WIDTH-1:0] b_re,
    input  logic signed [WORD_WIDTH-1:0] b_im,
    output logic                         prod_valid,
    output logic        [TAG_W-1:0]      prod_tag,
    output logic signed [PW-1:0]         prod_re,
    output logic signed [PW-1:0]         prod_im,
    output logic                         busy
);

    logic signed [PW-1:0]    re_calc;
    logic signed [PW-1:0]    im_calc;
    logic signed [PW-1:0]    re_pipe  [MULT_LATENCY];
    logic signed [PW-1:0]    im_pipe  [MULT_LATENCY];
    logic        [TAG_W-1:0] tag_pipe [MULT_LATENCY];
    logic [MULT_LATENCY-1:0] valid_pipe;

    // Operands are widened before multiplying so no product bit is lost.
    always_comb begin
        re_calc = PW'(a_re) * PW'(b_re) - PW'(a_im) * PW'(b_im);
        im_calc = PW'(a_re) * PW'(b_im) + PW'(a_im) * PW'(b_re);
    end

    // Data and tags need no reset: they only matter alongside a valid bit.
    always_ff @(posedge clk) begin
        re_pipe[0]  <= re_calc;
        im_pipe[0]  <= im_calc;
        tag_pipe[0] <= tag;
        for (int i = 1; i < MULT_LATENCY; i++) begin
            re_pipe[i]  <= re_pipe[i-1];
            im_pipe[i]  <= im_pipe[i-1];
            tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe[0] <= valid;
            for (int i = 1; i < MULT_LATENCY; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
            end
        end
    end

    assign prod_valid = valid_pipe[MULT_LATENCY-1];
    assign prod_tag   = tag_pipe[MULT_LATENCY-1];
    assign prod_re    = re_pipe[MULT_LATENCY-1];
    assign prod_im    = im_pipe[MULT_LATENCY-1];
    assign busy       = |valid_pipe;

endmodule

// File: rtl/sdft_bin_engine.sv
// sdft_bin_engine
// Sliding-DFT bin update: X_k(new) = W_k * (d(X_k(prev)) + diff), rounded and
// saturated, with bin index / channel tags carried alongside the data.
// Ports:
//   clk, reset_n         : clock, async active-low reset
//   i_valid, i_damp      : sample valid, apply leaky damping to Xk_prev
//   sample_diff          : x[n] - x[n-N]
//   twiddle, Xk_prev     : {re, im} twiddle (Q TW_FRAC) and previous bin
//   i_idx, i_chan        : bin index and channel tags
//   i_ovf_clr            : clear sticky overflow
//   o_valid, o_Xk        : write-back enable and updated {re, im} bin
//   o_idx, o_chan        : tags aligned with o_Xk
//   o_sat, o_ovf         : this result saturated, sticky overflow
//   o_busy               : a sample is still travelling through the pipeline
// Latency is MULT_LATENCY + 2 cycles, one sample per cycle, no backpressure.
module sdft_bin_engine
    import sdft_pkg::*;
#(
    parameter  int WORD_WIDTH   = 16,
    parameter  int FFT_SIZE     = 512,
    parameter  int CHANNELS     = 1,
    parameter  int MULT_LATENCY = 3,
    parameter  int TW_FRAC      = WORD_WIDTH - 2,
    parameter  int DAMP_SHIFT   = 8,
    localparam int IDX_W        = $clog2(FFT_SIZE),
    localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_valid,
    input  logic                         i_damp,
    input  logic signed [WORD_WIDTH-1:0] sample_diff,
    input  logic [2*WORD_WIDTH-1:0]      twiddle,
    input  logic [2*WORD_WIDTH-1:0]      Xk_prev,
    input  logic [IDX_W-1:0]             i_idx,
    input  logic [CH_W-1:0]              i_chan,
    input  logic                         i_ovf_clr,
    output logic                         o_valid,
    output logic [2*WORD_WIDTH-1:0]      o_Xk,
    output logic [IDX_W-1:0]             o_idx,
    output logic [CH_W-1:0]              o_chan,
    output logic                         o_sat,
    output logic                         o_ovf,
    output logic                         o_busy
);

    localparam int PW    = 2 * WORD_WIDTH + 1;
    localparam int TAG_W = IDX_W + CH_W + 1;

    logic signed [63:0] prev_re;
    logic signed [63:0] prev_im;
    logic signed [63:0] damp_re;
    logic signed [63:0] damp_im;
    logic signed [63:0] re_sum;
    sat_result_t        re_sum_sat;

    logic                         s1_valid;
    logic signed [WORD_WIDTH-1:0] s1_re;
    logic signed [WORD_WIDTH-1:0] s1_im;
    logic signed [WORD_WIDTH-1:0] s1_tw_re;
    logic signed [WORD_WIDTH-1:0] s1_tw_im;
    logic [IDX_W-1:0]             s1_idx;
    logic [CH_W-1:0]              s1_chan;
    logic                         s1_sat;

    logic                 prod_valid;
    logic [TAG_W-1:0]     prod_tag;
    logic signed [PW-1:0] prod_re;
    logic signed [PW-1:0] prod_im;
    logic                 mult_busy;

    logic signed [63:0] rnd_re;
    logic signed [63:0] rnd_im;
    sat_result_t        out_re_sat;
    sat_result_t        out_im_sat;
    logic               out_sat;
    logic [127:0]       out_bus;

    // Stage 1 arithmetic. Damping x - (x >>> s) shrinks magnitude so it can
    // never overflow; only the real-part sum with sample_diff can clamp.
    always_comb begin
        prev_re = cplx_re(128'(Xk_prev), WORD_WIDTH);
        prev_im = cplx_im(128'(Xk_prev), WORD_WIDTH);
        damp_re = prev_re;
        damp_im = prev_im;
        if (i_damp) begin
            damp_re = prev_re - (prev_re >>> DAMP_SHIFT);
            damp_im = prev_im - (prev_im >>> DAMP_SHIFT);
        end
        re_sum     = damp_re + 64'(sample_diff);
        re_sum_sat = saturate(re_sum, WORD_WIDTH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_tw_re <= '0;
            s1_tw_im <= '0;
            s1_idx   <= '0;
            s1_chan  <= '0;
            s1_sat   <= 1'b0;
        end else begin
            s1_valid <= i_valid;
            s1_re    <= re_sum_sat.value[WORD_WIDTH-1:0];
            s1_im    <= damp_im[WORD_WIDTH-1:0];
            s1_tw_re <= twiddle[2*WORD_WIDTH-1:WORD_WIDTH];
            s1_tw_im <= twiddle[WORD_WIDTH-1:0];
            s1_idx   <= i_idx;
            s1_chan  <= i_chan;
            s1_sat   <= re_sum_sat.sat;
        end
    end

    // Tags ride through the multiplier so they stay aligned by construction.
    sdft_cmult #(
        .WORD_WIDTH  (WORD_WIDTH),
        .MULT_LATENCY(MULT_LATENCY),
        .TAG_W       (TAG_W)
    ) u_cmult (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid     (s1_valid),
        .tag       ({s1_idx, s1_chan, s1_sat}),
        .a_re      (s1_tw_re),
        .a_im      (s1_tw_im),
        .b_re      (s1_re),
        .b_im      (s1_im),
        .prod_valid(prod_valid),
        .prod_tag  (prod_tag),
        .prod_re   (prod_re),
        .prod_im   (prod_im),
        .busy      (mult_busy)
    );

    always_comb begin
        rnd_re     = round_shift(64'(prod_re), TW_FRAC);
        rnd_im     = round_shift(64'(prod_im), TW_FRAC);
        out_re_sat = saturate(rnd_re, WORD_WIDTH);
        out_im_sat = saturate(rnd_im, WORD_WIDTH);
        out_sat    = prod_tag[0] | out_re_sat.sat | out_im_sat.sat;
        out_bus    = cplx_pack(out_re_sat.value, out_im_sat.value, WORD_WIDTH);
    end

    // Output registers hold the last valid result during gaps. Overflow is
    // raised on the edge that loads a saturated result and is also held
    // through the cycle it is displayed, so a simultaneous clear loses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_valid <= 1'b0;
            o_Xk    <= '0;
            o_idx   <= '0;
            o_chan  <= '0;
            o_sat   <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            o_valid <= prod_valid;
            if (prod_valid) begin
                o_Xk   <= out_bus[2*WORD_WIDTH-1:0];
                o_idx  <= prod_tag[TAG_W-1:CH_W+1];
                o_chan <= prod_tag[CH_W:1];
                o_sat  <= out_sat;
            end
            o_ovf <= (prod_valid & out_sat) | (o_valid & o_sat) | (o_ovf & ~i_ovf_clr);
        end
    end

    // A sample counts as in flight until it lands in the output register.
    assign o_busy = s1_valid | mult_busy;

endmodule

// File: doc/sdft_bin_engine.md
# sdft_bin_engine

Parametrised sliding-DFT bin update engine for the STFT datapath. Per valid input it computes X_k(new) = W_k · (d(X_k(prev)) + Δx), where d() is an optional leaky damping for long-run stability. The block rounds and saturates the result and reports overflow per sample and stickily. It streams bin index and channel tags alongside the data, so one engine can serve several time-multiplexed channels between the bin-state RAM read port and its write-back port.

## Interface
- WORD_WIDTH, 16, signed width of each real/imag component and of sample_diff
- FFT_SIZE, 512, number of bins; index width IDX_W = $clog2(FFT_SIZE)
- CHANNELS, 1, number of time-multiplexed channels; tag width CH_W = max(1, $clog2(CHANNELS))
- MULT_LATENCY, 3, pipeline depth of the complex multiplier, ≥1
- TW_FRAC, WORD_WIDTH-2, twiddle fractional bits; +1.0 = 2^TW_FRAC
- DAMP_SHIFT, 8, damping shift; damped value = x − (x >>> DAMP_SHIFT)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_valid  in  1  input sample/bin valid
- i_damp  in  1  apply damping to Xk_prev for this sample
- sample_diff  in  WORD_WIDTH  signed x[n] − x[n−N]
- twiddle  in  2*WORD_WIDTH  {re, im}, signed, Q(TW_FRAC)
- Xk_prev  in  2*WORD_WIDTH  {re, im} previous bin value
- i_idx  in  IDX_W  bin index tag
- i_chan  in  CH_W  channel tag
- i_ovf_clr  in  1  clear sticky overflow
- o_valid  out  1  result valid (write-back enable)
- o_Xk  out  2*WORD_WIDTH  {re, im} updated bin
- o_idx  out  IDX_W  bin index tag aligned with o_Xk
- o_chan  out  CH_W  channel tag aligned with o_Xk
- o_sat  out  1  this result saturated at any stage
- o_ovf  out  1  sticky overflow
- o_busy  out  1  any valid sample in flight

## Operation
- Packing: real in the upper half, imag in the lower half, on every complex bus.
- Stage 1 (registered):
  - damping, if i_damp: r = x − (x >>> DAMP_SHIFT) per component, arithmetic shift, no saturation needed;
  - re_sum = r_re + sample_diff computed in WORD_WIDTH+1 bits, saturated to WORD_WIDTH; any saturation sets a sat tag;
  - im is passed unchanged.
- Multiplier stages: full-precision complex product P = tw · B; P_re = tw_re·B_re − tw_im·B_im and P_im = tw_re·B_im + tw_im·B_re, each in 2*WORD_WIDTH+1 bits.
- Output stage (registered):
  - round half-up: (P + 2^(TW_FRAC−1)) >>> TW_FRAC;
  - saturate to WORD_WIDTH signed; saturation ORs into the sat tag.
- Tags (valid, idx, chan, sat) travel in a shift pipeline of identical depth. Invalid slots still advance but never assert o_valid.
- No backpressure: the block accepts one sample per cycle unconditionally.
- o_ovf sets on any cycle with o_valid && o_sat. i_ovf_clr clears it. If set and clear occur in the same cycle, set wins.
- o_busy = OR of all pipeline valid bits (combinational from registers).

## Timing
- Latency L = MULT_LATENCY + 2 cycles from i_valid to o_valid. Default L = 5.
- Throughput: 1 sample/cycle, with arbitrary gaps allowed.
- Order of outputs equals order of inputs.
- Reset (async assert, sync release): o_valid=0, o_Xk=0, o_idx=0, o_chan=0, o_sat=0, o_ovf=0, o_busy=0.
- Reset mid-stream: all in-flight samples are dropped. No output appears after release unless new i_valid arrives.
- o_busy falls L cycles after the last accepted i_valid.
- Data registers may hold stale values when o_valid=0. The bench checks them only when o_valid=1.

## Structure
- Package sdft_pkg: complex pack/unpack helpers, a saturate(width) function, and a round_shift function.
- Sub-module sdft_cmult: pipelined full-precision complex multiplier with MULT_LATENCY registers, reset_n on valid only. The engine instantiates it once; rounding and saturation stay in the engine.

## Test plan
1. Identity (W=16, TW_FRAC=14): tw={16384,0}, Xk_prev={100,−50}, diff=20, damp=0, idx=37 → 5 cycles later o_valid=1, o_Xk={120,−50}, o_idx=37, o_sat=0.
2. Rotation and rounding:
   - tw={0,16384}, Xk_prev={1000,0}, diff=0 → {0,1000};
   - tw={8192,0}, Xk_prev={3,−3} → {2,−1}.
3. Saturation:
   - Xk_prev={32767,0}, diff=1, tw=1.0 → {32767,0}, o_sat=1, o_ovf=1 and held;
   - i_ovf_clr alone → o_ovf=0;
   - clear coincident with a new saturated output → o_ovf stays 1.
4. Damping (DAMP_SHIFT=8): Xk_prev={25600,−25600}, damp=1, diff=0, tw=1.0 → {25500,−25500}.
5. Stream 512 bins on CHANNELS=2 with random valid gaps vs. a reference model → all outputs match in order with correct idx/chan; o_busy deasserts exactly 5 cycles after the last input.
6. Pull reset_n low with 3 samples in flight → o_valid and o_busy drop immediately; after release, no output for 10 idle cycles.
